// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter. Serialises one byte into an asynchronous frame made of a
// start bit, DBIT data bits (LSB first), an optional parity bit and a stop
// period of SB_TICK ticks. Bit timing comes from the shared x16 oversampling
// tick, so every start, data and parity bit lasts exactly 16 ticks.
//
// Parameters:
//   DBIT    data bits per frame, 5..8
//   SB_TICK stop length in ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
//   PARITY  0 = none, 1 = even, 2 = odd
//
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_s_tick       x16 baud enable pulse, one clock wide
//   i_tx_start     send request, honoured only while idle
//   i_data         byte to send, captured on acceptance
//   o_tx           serial line, idles high, driven from a register
//   o_busy         high while a frame is in progress
//   o_tx_done_tick one-clock pulse on the final stop tick
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_s_tick,
    input  logic       i_tx_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_tx_done_tick
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [4:0] TICK_LAST  = 5'd15;
    localparam logic [4:0] STOP_LAST  = 5'(SB_TICK - 1);
    localparam logic [2:0] DATA_LAST  = 3'(DBIT - 1);
    localparam logic       HAS_PARITY = (PARITY == 32'sd1) || (PARITY == 32'sd2);
    localparam logic       ODD_PARITY = (PARITY == 32'sd2);

    // Line level for the parity bit given the XOR of all data bits.
    function automatic logic parity_line(input logic acc);
        return acc ^ ODD_PARITY;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [4:0] s_r;
    logic [4:0] s_next_s;
    logic [2:0] n_r;
    logic [2:0] n_next_s;
    logic [7:0] b_r;
    logic [7:0] b_next_s;
    logic       p_r;
    logic       p_next_s;
    logic       tx_r;
    logic       tx_next_s;
    logic       done_s;

    // State and datapath registers; reset parks the line high in idle.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
            s_r     <= 5'd0;
            n_r     <= 3'd0;
            b_r     <= 8'd0;
            p_r     <= 1'b0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_next_s;
            s_r     <= s_next_s;
            n_r     <= n_next_s;
            b_r     <= b_next_s;
            p_r     <= p_next_s;
            tx_r    <= tx_next_s;
        end
    end

    // Next-state logic. The next line level is computed here and registered,
    // so o_tx changes on the edge that consumes the terminating tick.
    always_comb begin
        state_next_s = state_r;
        s_next_s     = s_r;
        n_next_s     = n_r;
        b_next_s     = b_r;
        p_next_s     = p_r;
        tx_next_s    = tx_r;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_tx_start) begin
                    state_next_s = ST_START;
                    s_next_s     = 5'd0;
                    b_next_s     = i_data;
                    p_next_s     = 1'b0;
                    tx_next_s    = 1'b0;
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            ST_START: begin
                if (i_s_tick) begin
                    if (s_r == TICK_LAST) begin
                        state_next_s = ST_DATA;
                        s_next_s     = 5'd0;
                        n_next_s     = 3'd0;
                        tx_next_s    = b_r[0];
                    end else begin
                        s_next_s = s_r + 5'd1;
                    end
                end else begin
                    s_next_s = s_r;
                end
            end
            ST_DATA: begin
                if (i_s_tick) begin
                    if (s_r == TICK_LAST) begin
                        // Fold the outgoing bit into parity before shifting it out.
                        p_next_s = p_r ^ b_r[0];
                        b_next_s = {1'b0, b_r[7:1]};
                        s_next_s = 5'd0;
                        if (n_r == DATA_LAST) begin
                            if (HAS_PARITY) begin
                                state_next_s = ST_PARITY;
                                tx_next_s    = parity_line(p_r ^ b_r[0]);
                            end else begin
                                state_next_s = ST_STOP;
                                tx_next_s    = 1'b1;
                            end
                        end else begin
                            n_next_s  = n_r + 3'd1;
                            tx_next_s = b_r[1];
                        end
                    end else begin
                        s_next_s = s_r + 5'd1;
                    end
                end else begin
                    s_next_s = s_r;
                end
            end
            ST_PARITY: begin
                if (i_s_tick) begin
                    if (s_r == TICK_LAST) begin
                        state_next_s = ST_STOP;
                        s_next_s     = 5'd0;
                        tx_next_s    = 1'b1;
                    end else begin
                        s_next_s = s_r + 5'd1;
                    end
                end else begin
                    s_next_s = s_r;
                end
            end
            ST_STOP: begin
                tx_next_s = 1'b1;
                if (i_s_tick) begin
                    if (s_r == STOP_LAST) begin
                        // Returning to idle here lets a request held in the next
                        // clock start a new frame with no extra idle time.
                        state_next_s = ST_IDLE;
                        s_next_s     = 5'd0;
                        done_s       = 1'b1;
                    end else begin
                        s_next_s = s_r + 5'd1;
                    end
                end else begin
                    s_next_s = s_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                s_next_s     = 5'd0;
                n_next_s     = 3'd0;
                b_next_s     = 8'd0;
                p_next_s     = 1'b0;
                tx_next_s    = 1'b1;
            end
        endcase
    end

    assign o_tx           = tx_r;
    assign o_busy         = (state_r != ST_IDLE);
    assign o_tx_done_tick = done_s;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises one parallel byte into an asynchronous frame: start bit, DBIT data bits LSB first, optional parity bit, and stop bit(s). It shares the x16 oversampling baud tick (i_s_tick) with the UART receiver, so both ends of the link run from one baud generator. It sits between the transmit-side data source (FIFO or interface FSM) and the serial line pin.

## Interface
- DBIT, 8: data bits per frame; legal 5..8.
- SB_TICK, 16: stop-bit length in ticks; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.

Ports:
- i_clock  in  1  system clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_s_tick  in  1  baud x16 enable pulse, one clock wide.
- i_tx_start  in  1  request to send i_data; honoured only in idle.
- i_data  in  8  byte to send; bits [DBIT-1:0] used, sampled only on acceptance.
- o_tx  out  1  serial line output; idle level high; registered.
- o_busy  out  1  high whenever state is not idle.
- o_tx_done_tick  out  1  one-clock pulse at frame end.

## Operation
- Internal registers:
  - state (idle, start, data, parity, stop).
  - s, 5-bit tick counter.
  - n, 3-bit bit counter.
  - b, 8-bit shift register.
  - tx, output bit register; o_tx = tx.
  - p, parity accumulator.
- idle: tx = 1.
  - If i_tx_start = 1: state -> start, s = 0, b = i_data, p = 0, tx = 0.
  - i_s_tick is ignored in idle.
- start: tx = 0. On each tick, s increments.
  - At tick with s = 15: state -> data, s = 0, n = 0, tx = b[0].
- data: tx = b[0]. On each tick, s increments.
  - At tick with s = 15: p ^= b[0], b shifts right (b = b >> 1), s = 0.
  - If n = DBIT-1: go to parity if PARITY != 0, else to stop. tx = next bit (parity or 1).
  - Otherwise n increments and tx = new b[0].
- parity: tx = p for PARITY = 1, ~p for PARITY = 2.
  - At tick with s = 15: state -> stop, s = 0, tx = 1.
- stop: tx = 1. On each tick, s increments.
  - At tick with s = SB_TICK-1: state -> idle, o_tx_done_tick = 1 for that clock only.
- Ignored inputs:
  - i_tx_start while not idle is ignored; the frame is not corrupted.
  - i_data changes after acceptance have no effect.
- Back-to-back frames: i_tx_start high in the clock after done_tick starts the next frame. There is no extra idle bit time.
- Reset (i_reset = 0, any time, including mid-frame) forces immediately:
  - state = idle, s = 0, n = 0, b = 0, p = 0.
  - o_tx = 1, o_busy = 0, o_tx_done_tick = 0.
  - On release, the block waits in idle for a new i_tx_start.

## Timing
- Output reset values: o_tx = 1, o_busy = 0, o_tx_done_tick = 0.
- Start latency: o_tx falls on the first rising edge after the cycle in which i_tx_start is seen in idle. o_busy rises on the same edge.
- Bit lengths:
  - Start, each data bit, and parity: exactly 16 i_s_tick pulses each.
  - Stop: SB_TICK pulses.
- Frame length in ticks: 16 × (1 + DBIT + (PARITY != 0)) + SB_TICK.
  - Example: DBIT = 8, no parity, SB_TICK = 16 gives 160 ticks.
- Bit transitions on o_tx occur on the clock edge that consumes the terminating tick. There are no combinational glitches on o_tx.
- o_tx_done_tick is combinational from state/s/i_s_tick and is high during the last stop tick cycle. o_busy drops on the following edge.
- Fixed widths: s is 5 bits, so SB_TICK ≤ 32; n is 3 bits, so DBIT ≤ 8.

## Test plan
- Reset: assert i_reset = 0 mid data bit of a frame.
  - Required: o_tx = 1 and o_busy = 0 immediately.
  - Required: after release with no i_tx_start, no activity for 200 ticks.
- Basic frame: tick every 4 clocks, send 0x55 with DBIT = 8, PARITY = 0, SB_TICK = 16.
  - Required o_tx sequence, 16 ticks each: 0, 1,0,1,0,1,0,1,0, then 1.
  - Required: done_tick exactly once, at tick 160.
- Parity: send 0xA5.
  - PARITY = 1 (even): parity bit = 0.
  - PARITY = 2 (odd): parity bit = 1.
  - Send 0x07 with PARITY = 1: parity bit = 1.
  - Required: frame length = 176 ticks.
- Busy and ignored requests: pulse i_tx_start with i_data = 0xFF during the data phase of a 0x3C frame.
  - Required: the 0x3C frame completes unchanged.
  - Required: no second frame is started.
- Back-to-back and loopback: hold i_tx_start = 1 with 0x12 then 0x34.
  - Required: the two frames are contiguous, with the stop bit followed directly by the next start bit.
  - Loopback into the receiver with the shared i_s_tick: the receiver reports 0x12 and then 0x34.
- Configuration: DBIT = 7, SB_TICK = 32, send 0x81.
  - Required: only 7 data bits sent (1,0,0,0,0,0,0).
  - Required: stop level held for 32 ticks.
